// File: rtl/whack_judge.sv
// whack_judge: judges player whacks against the moles of the current round,
// keeps a saturating BCD score and a lives counter, and runs the
// IDLE / PLAY / OVER game state machine.
// Optional build macro: WRONG_WHACK_PENALTY_EN -- a whack on an empty hole
// costs one life (at most one life per cycle, shared with a round-end miss).
// Handshake: none; start is a single-cycle request, mole_clk is a slow level
// whose rising edge marks a new round, switch toggles in either direction
// are whacks. All outputs are registered.
module whack_judge #(
    parameter int NUM_HOLES    = 18,
    parameter int LIVES        = 3,
    parameter int LIVES_W      = 2,
    parameter int SCORE_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mole_clk,
    input  logic [NUM_HOLES-1:0]      mole_positions,
    input  logic [NUM_HOLES-1:0]      switches,
    output logic [NUM_HOLES-1:0]      active_moles,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [LIVES_W-1:0]        lives,
    output logic                      hit_pulse,
    output logic                      miss_pulse,
    output logic                      playing,
    output logic                      game_over
);

    localparam int                 SCORE_W    = 4 * SCORE_DIGITS;
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] ONE_LIFE   = LIVES_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_HOLES-1:0]  r_active;
    logic [SCORE_W-1:0]    r_score;
    logic [LIVES_W-1:0]    r_lives;
    logic                  r_hit;
    logic                  r_miss;

    logic                  r_mclk_s1;
    logic                  r_mclk_s2;
    logic                  r_mclk_prev;
    logic [NUM_HOLES-1:0]  r_sw_s1;
    logic [NUM_HOLES-1:0]  r_sw_s2;
    logic [NUM_HOLES-1:0]  r_sw_prev;
    logic [1:0]            r_settle;

    logic                  w_valid;
    logic                  w_tick;
    logic [NUM_HOLES-1:0]  w_wv;
    logic [NUM_HOLES-1:0]  w_hits;
    logic [NUM_HOLES-1:0]  w_residual;
    logic                  w_round_miss;
    logic                  w_lose;
    logic [SCORE_W-1:0]    w_score_inc;

    // BCD ripple increment that holds at all-nines instead of wrapping.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] res;
        logic               carry;
        logic               all_nines;
        logic [3:0]         d;
        res       = v;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) all_nines = 1'b0;
        end
        if (!all_nines) begin
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                d = v[4*i +: 4];
                if (carry) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end
                res[4*i +: 4] = d;
            end
        end
        return res;
    endfunction

    // Two-flop synchronizers plus previous-value registers; the settle
    // counter blanks edge detection until prev holds a synchronized value,
    // so levels present at reset never look like ticks or whacks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mclk_s1   <= 1'b0;
            r_mclk_s2   <= 1'b0;
            r_mclk_prev <= 1'b0;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_sw_prev   <= '0;
            r_settle    <= 2'd0;
        end else begin
            r_mclk_s1   <= mole_clk;
            r_mclk_s2   <= r_mclk_s1;
            r_mclk_prev <= r_mclk_s2;
            r_sw_s1     <= switches;
            r_sw_s2     <= r_sw_s1;
            r_sw_prev   <= r_sw_s2;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
        end
    end

    assign w_valid      = (r_settle == 2'd3);
    assign w_tick       = w_valid & r_mclk_s2 & ~r_mclk_prev;
    assign w_wv         = {NUM_HOLES{w_valid}} & (r_sw_s2 ^ r_sw_prev);
    assign w_hits       = w_wv & r_active;
    assign w_residual   = r_active & ~w_hits;
    assign w_round_miss = w_tick && (w_residual != '0);
    assign w_score_inc  = bcd_inc(r_score);

`ifdef WRONG_WHACK_PENALTY_EN
    logic w_wrong;
    assign w_wrong = ((w_wv & ~r_active) != '0);
    assign w_lose  = w_round_miss | w_wrong;
`else
    assign w_lose  = w_round_miss;
`endif

    // Game state machine: hit judging, round load, life loss and score.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_active <= '0;
            r_score  <= '0;
            r_lives  <= LIVES_INIT;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                IDLE, OVER: begin
                    if (start) begin
                        r_state  <= PLAY;
                        r_active <= '0;
                        r_score  <= '0;
                        r_lives  <= LIVES_INIT;
                    end
                end
                PLAY: begin
                    if (w_hits != '0) begin
                        r_hit   <= 1'b1;
                        r_score <= w_score_inc;
                    end
                    // A tick replaces the round; hits were judged against
                    // the outgoing round above.
                    if (w_tick) begin
                        r_active <= mole_positions;
                    end else begin
                        r_active <= r_active & ~w_hits;
                    end
                    if (w_lose) begin
                        r_miss <= 1'b1;
                        if (r_lives != '0) r_lives <= r_lives - ONE_LIFE;
                        if (r_lives <= ONE_LIFE) r_state <= OVER;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign active_moles = r_active;
    assign score_bcd    = r_score;
    assign lives        = r_lives;
    assign hit_pulse    = r_hit;
    assign miss_pulse   = r_miss;
    assign playing      = (r_state == PLAY);
    assign game_over    = (r_state == OVER);

endmodule
